lcd_fb_fetch: RTL and testbench

Frame-buffer fetch engine between the dual-port frame-buffer RAM bank (port B, read only) and the LCD pixel timing generator. On each frame-start pulse it reads a contiguous run of 32-bit words from the RAM. Reads are issued at up to one word per clock, with credit-based flow control. The returned words are buffered in a first-word-fall-through FIFO and presented on a valid/ready pixel-word stream. It reports frame completion, busy status, and sticky underflow/overrun errors.

---
 rtl/lcd_fb_fetch.sv | 147 ++++++++++++++
 tb/tb_lcd_fb_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_fetch.sv
// Frame-buffer fetch engine: streams a contiguous run of RAM words into a
// first-word-fall-through FIFO with credit-limited, one-word-per-clock reads.
module lcd_fb_fetch #(
    parameter int ADR_WIDTH  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  ENABLE,
    input  logic                  FRAME_START,
    input  logic [ADR_WIDTH-1:0]  FB_BASE,
    input  logic [ADR_WIDTH-1:0]  FB_WORDS,
    output logic                  CSB,
    output logic [ADR_WIDTH-1:0]  ADDRB,
    output logic                  WEB,
    output logic [3:0]            BWB,
    input  logic [DATA_WIDTH-1:0] DOB,
    output logic [DATA_WIDTH-1:0] PIX_DATA,
    output logic                  PIX_VALID,
    input  logic                  PIX_READY,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic                  UNDERFLOW,
    output logic                  OVERRUN,
    input  logic                  CLR_ERR
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

    state_t                state;
    logic [ADR_WIDTH-1:0]  addr;
    logic [ADR_WIDTH-1:0]  remaining;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           fifo_count;

    logic [PW+1:0]         credit_sum;
    logic                  active;
    logic                  start;
    logic                  abort;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  flush_fifo;
    logic [ADR_WIDTH-1:0]  base_addr;
    logic [ADR_WIDTH-1:0]  base_rem;
    logic [ADR_WIDTH-1:0]  rem_next;

    // In IDLE the first read is issued straight from FB_BASE/FB_WORDS so the
    // accepting edge already drives CSB; in-flight reads are CSB plus rd_vld.
    always_comb begin
        active     = (state == FETCH) || (state == DRAIN);
        start      = FRAME_START & ENABLE & (state == IDLE);
        abort      = active & ~ENABLE;
        credit_sum = {1'b0, fifo_count} + (PW+2)'(CSB) + (PW+2)'(rd_vld);
        base_addr  = (state == IDLE) ? FB_BASE : addr;
        base_rem   = (state == IDLE) ? FB_WORDS : remaining;
        issue      = (start | ((state == FETCH) & ENABLE)) & (base_rem != '0)
                     & (credit_sum < (PW+2)'(FIFO_DEPTH));
        rem_next   = issue ? base_rem - ADR_WIDTH'(1) : base_rem;
        push       = rd_vld & ENABLE & (state != FLUSH);
        pop        = PIX_VALID & PIX_READY;
        flush_fifo = abort | (state == FLUSH);
    end

    assign PIX_VALID = (fifo_count != '0);
    assign PIX_DATA  = PIX_VALID ? fifo_mem[rd_ptr] : '0;
    assign BUSY      = (state != IDLE);
    assign WEB       = 1'b0;
    assign BWB       = 4'b0000;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            CSB        <= 1'b0;
            ADDRB      <= '0;
            rd_vld     <= 1'b0;
            FRAME_DONE <= 1'b0;
            UNDERFLOW  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            CSB        <= issue;
            rd_vld     <= CSB;
            FRAME_DONE <= 1'b0;
            if (issue)
                ADDRB <= base_addr;
            if (start || (state == FETCH)) begin
                addr      <= issue ? base_addr + ADR_WIDTH'(1) : base_addr;
                remaining <= rem_next;
            end
            // Leaving DRAIN/FLUSH when CSB is low means the last return lands this edge.
            case (state)
                IDLE:  if (start) state <= (rem_next == '0) ? DRAIN : FETCH;
                FETCH: if (abort) state <= FLUSH;
                       else if (rem_next == '0) state <= DRAIN;
                DRAIN: if (abort) state <= FLUSH;
                       else if (!CSB) begin
                           state      <= IDLE;
                           FRAME_DONE <= 1'b1;
                       end
                FLUSH: if (!CSB) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (FRAME_START && (state != IDLE))
                OVERRUN <= 1'b1;
            else if (CLR_ERR)
                OVERRUN <= 1'b0;
            if (active && PIX_READY && !PIX_VALID)
                UNDERFLOW <= 1'b1;
            else if (CLR_ERR)
                UNDERFLOW <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush_fifo) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (push)
            fifo_mem[wr_ptr] <= DOB;
    end
endmodule

// File: tb/tb_lcd_fb_fetch.sv
// Bench for lcd_fb_fetch: RAM model, directed frames, random frames checked
// against expected address/data sequences derived from base and length.
module tb_lcd_fb_fetch;
    logic        HCLK = 1'b0;
    logic        HRESETn, ENABLE, FRAME_START, PIX_READY, CLR_ERR;
    logic [15:0] FB_BASE, FB_WORDS, ADDRB;
    logic        CSB, WEB;
    logic [3:0]  BWB;
    logic [31:0] DOB, PIX_DATA;
    logic        PIX_VALID, BUSY, FRAME_DONE, UNDERFLOW, OVERRUN;

    lcd_fb_fetch #(.ADR_WIDTH(16), .DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .ENABLE(ENABLE), .FRAME_START(FRAME_START),
        .FB_BASE(FB_BASE), .FB_WORDS(FB_WORDS), .CSB(CSB), .ADDRB(ADDRB),
        .WEB(WEB), .BWB(BWB), .DOB(DOB), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
        .PIX_READY(PIX_READY), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
        .UNDERFLOW(UNDERFLOW), .OVERRUN(OVERRUN), .CLR_ERR(CLR_ERR)
    );

    always #5 HCLK = ~HCLK;

    logic [31:0] mem [0:65535];
    always @(posedge HCLK) if (CSB) DOB <= mem[ADDRB];

    int          total = 0;
    int          bad = 0;
    logic [15:0] addr_q[$];
    int          csb_cyc_q[$];
    logic [31:0] data_q[$];
    int          done_cnt, busy_cnt, cyc, first_valid, last_csb, done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        addr_q.delete(); csb_cyc_q.delete(); data_q.delete();
        done_cnt = 0; busy_cnt = 0; cyc = 0;
        first_valid = -1; last_csb = -1; done_cyc = -1;
    endtask

    // pol: 0 never ready, 1 ready when valid, 2 random when valid, 3 ready regardless
    task automatic sample(input int pol);
        case (pol)
            0:       PIX_READY = 1'b0;
            1:       PIX_READY = PIX_VALID;
            2:       PIX_READY = PIX_VALID && ($urandom_range(0, 1) == 1);
            default: PIX_READY = 1'b1;
        endcase
        if (CSB) begin
            addr_q.push_back(ADDRB);
            csb_cyc_q.push_back(cyc);
            last_csb = cyc;
        end
        if (PIX_VALID && PIX_READY) data_q.push_back(PIX_DATA);
        if (PIX_VALID && first_valid < 0) first_valid = cyc;
        if (FRAME_DONE) begin done_cnt++; done_cyc = cyc; end
        if (BUSY) busy_cnt++;
        cyc++;
    endtask

    task automatic step(input int pol);
        sample(pol);
        @(negedge HCLK);
    endtask

    task automatic launch(input logic [15:0] base, input logic [15:0] words);
        FB_BASE = base; FB_WORDS = words; FRAME_START = 1'b1;
        @(negedge HCLK);
        FRAME_START = 1'b0;
        clear_rec();
    endtask

    task automatic finish_frame(input int pol);
        int n = 0;
        while ((BUSY || PIX_VALID) && n < 3000) begin
            step(pol);
            n++;
        end
        chk("frame_timeout", 32'(n < 3000), 32'd1);
        repeat (3) step(1);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] base, input int words,
                               input logic exp_uf);
        logic [15:0] a;
        chk({tag, "_reads"}, 32'(addr_q.size()), 32'(words));
        for (int j = 0; j < addr_q.size() && j < words; j++) begin
            a = base + 16'(j);
            chk({tag, "_addr"}, 32'(addr_q[j]), 32'(a));
        end
        chk({tag, "_nwords"}, 32'(data_q.size()), 32'(words));
        for (int j = 0; j < data_q.size() && j < words; j++) begin
            a = base + 16'(j);
            chk({tag, "_data"}, data_q[j], mem[a]);
        end
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        if (words > 0) chk({tag, "_done_time"}, 32'(done_cyc), 32'(last_csb + 2));
        chk({tag, "_underflow"}, 32'(UNDERFLOW), 32'(exp_uf));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_csb"}, 32'(CSB), 32'd0);
        chk({tag, "_addrb"}, 32'(ADDRB), 32'd0);
        chk({tag, "_web"}, 32'(WEB), 32'd0);
        chk({tag, "_bwb"}, 32'(BWB), 32'd0);
        chk({tag, "_valid"}, 32'(PIX_VALID), 32'd0);
        chk({tag, "_data"}, PIX_DATA, 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_done"}, 32'(FRAME_DONE), 32'd0);
        chk({tag, "_uf"}, 32'(UNDERFLOW), 32'd0);
        chk({tag, "_ovr"}, 32'(OVERRUN), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] b;
        int          w, k;
        HRESETn = 1'b0; ENABLE = 1'b1; FRAME_START = 1'b0; PIX_READY = 1'b0;
        CLR_ERR = 1'b0; FB_BASE = '0; FB_WORDS = '0;
        for (int i = 0; i < 65536; i++) mem[i] = i;
        repeat (3) @(negedge HCLK);
        chk_reset_vals("rst");
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Basic 8-word frame, RAM word[i] = i
        launch(16'h0100, 16'd8);
        chk("t1_busy_rise", 32'(BUSY), 32'd1);
        chk("t1_first_csb", 32'(CSB), 32'd1);
        chk("t1_first_addr", 32'(ADDRB), 32'h0100);
        finish_frame(1);
        check_frame("t1", 16'h0100, 8, 1'b0);
        chk("t1_first_valid", 32'(first_valid), 32'd2);
        for (int j = 0; j < csb_cyc_q.size(); j++)
            chk("t1_csb_consecutive", 32'(csb_cyc_q[j]), 32'(j));

        for (int i = 0; i < 65536; i++) mem[i] = $urandom;

        // Backpressure: credit must stop reads at FIFO depth
        b = 16'($urandom);
        launch(b, 16'd40);
        repeat (30) step(0);
        chk("t2_reads_stalled", 32'(addr_q.size()), 32'd16);
        chk("t2_fifo_count", 32'(dut.fifo_count), 32'd16);
        chk("t2_valid", 32'(PIX_VALID), 32'd1);
        finish_frame(1);
        check_frame("t2", b, 40, 1'b0);

        // Address wrap
        launch(16'hFFFE, 16'd4);
        finish_frame(2);
        check_frame("t3", 16'hFFFE, 4, 1'b0);

        // Zero-length frame
        launch(16'h1234, 16'd0);
        finish_frame(1);
        chk("t4_no_csb", 32'(addr_q.size()), 32'd0);
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd1);

        // Overrun: restart while busy is ignored; set beats a same-cycle clear
        b = 16'($urandom);
        launch(b, 16'd20);
        repeat (3) step(1);
        FRAME_START = 1'b1; FB_BASE = b + 16'h4000;
        step(1);
        FRAME_START = 1'b0;
        chk("t5_overrun_set", 32'(OVERRUN), 32'd1);
        step(1);
        FRAME_START = 1'b1; CLR_ERR = 1'b1;
        step(1);
        FRAME_START = 1'b0; CLR_ERR = 1'b0;
        chk("t5_set_wins", 32'(OVERRUN), 32'd1);
        finish_frame(1);
        check_frame("t5", b, 20, 1'b0);
        CLR_ERR = 1'b1;
        @(negedge HCLK);
        CLR_ERR = 1'b0;
        chk("t5_overrun_clr", 32'(OVERRUN), 32'd0);

        // Abort after 5 reads
        b = 16'($urandom);
        launch(b, 16'd30);
        k = 0;
        while (k < 50) begin
            sample(0);
            if (addr_q.size() >= 5) break;
            @(negedge HCLK);
            k++;
        end
        ENABLE = 1'b0;
        @(negedge HCLK);
        chk("t6_flush_valid", 32'(PIX_VALID), 32'd0);
        chk("t6_flush_csb", 32'(CSB), 32'd0);
        k = 0;
        while (BUSY && k < 5) begin step(0); k++; end
        chk("t6_idle_in_3", 32'(k + 1 <= 3), 32'd1);
        repeat (3) step(0);
        chk("t6_reads", 32'(addr_q.size()), 32'd5);
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        ENABLE = 1'b1;
        @(negedge HCLK);

        // Underflow: consumer ready on an empty FIFO during fetch
        b = 16'($urandom);
        launch(b, 16'd3);
        sample(3);
        @(negedge HCLK);
        finish_frame(1);
        check_frame("t7", b, 3, 1'b1);
        CLR_ERR = 1'b1;
        @(negedge HCLK);
        CLR_ERR = 1'b0;
        chk("t7_uf_clr", 32'(UNDERFLOW), 32'd0);

        // Reset mid-fetch, with a sticky flag set beforehand
        b = 16'($urandom);
        launch(b, 16'd20);
        repeat (3) step(1);
        FRAME_START = 1'b1;
        step(1);
        FRAME_START = 1'b0;
        chk("t8_pre_overrun", 32'(OVERRUN), 32'd1);
        HRESETn = 1'b0;
        #1;
        chk_reset_vals("t8_async");
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        b = 16'($urandom);
        launch(b, 16'd12);
        finish_frame(1);
        check_frame("t8_after", b, 12, 1'b0);

        // Random frames with random consumer stalls
        for (int r = 0; r < 6; r++) begin
            b = 16'($urandom);
            w = $urandom_range(1, 40);
            launch(b, 16'(w));
            finish_frame(2);
            check_frame("rnd", b, w, 1'b0);
            chk("rnd_overrun", 32'(OVERRUN), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
